// File: rtl/layer_sequencer_if.sv
// Handshake and per-layer configuration bundle between the layer sequencer
// (master) and the layer compute engine (slave).
interface layer_sequencer_if #(
   parameter int ADDR_W = 22
);
   logic              start_layer;
   logic              done_layer;
   logic [8:0]        ifm_size;
   logic [10:0]       ifm_channel;
   logic [1:0]        kernel_size;
   logic [10:0]       num_filter;
   logic              maxpool_mode;
   logic [1:0]        maxpool_stride;
   logic              upsample_mode;
   logic [ADDR_W-1:0] start_read_addr;
   logic [ADDR_W-1:0] start_write_addr;

   modport master (
      output start_layer, ifm_size, ifm_channel, kernel_size, num_filter,
             maxpool_mode, maxpool_stride, upsample_mode,
             start_read_addr, start_write_addr,
      input  done_layer
   );

   modport slave (
      input  start_layer, ifm_size, ifm_channel, kernel_size, num_filter,
             maxpool_mode, maxpool_stride, upsample_mode,
             start_read_addr, start_write_addr,
      output done_layer
   );
endinterface

// File: rtl/layer_sequencer.sv
// Steps a layer engine through a contiguous range of a writable layer config
// table, with per-layer watchdog, abort and range checking.
module layer_sequencer #(
   parameter  int NUM_LAYER    = 13,
   parameter  int OFM_RAM_SIZE = 2378675,
   parameter  int TIMEOUT_W    = 32,
   localparam int ADDR_W       = $clog2(OFM_RAM_SIZE),
   localparam int LIDX_W       = (NUM_LAYER > 1) ? $clog2(NUM_LAYER) : 1,
   localparam int CFG_W        = 37 + 2*ADDR_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cfg_we,
   input  logic [LIDX_W-1:0]    cfg_waddr,
   input  logic [CFG_W-1:0]     cfg_wdata,
   input  logic                 start_CNN,
   input  logic [LIDX_W-1:0]    first_layer,
   input  logic [LIDX_W-1:0]    last_layer,
   input  logic                 abort,
   input  logic [TIMEOUT_W-1:0] timeout_limit,
   output logic                 done_CNN,
   output logic                 busy,
   output logic                 error,
   output logic [1:0]           err_code,
   output logic [LIDX_W-1:0]    count_layer,
   layer_sequencer_if.master    eng
);

   localparam logic [LIDX_W:0] LAYER_CNT = (LIDX_W+1)'(NUM_LAYER);

   typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, DONE} state_t;

   typedef struct packed {
      logic [8:0]        ifm_size;
      logic [10:0]       ifm_channel;
      logic [1:0]        kernel_size;
      logic [10:0]       num_filter;
      logic              maxpool_mode;
      logic [1:0]        maxpool_stride;
      logic              upsample_mode;
      logic [ADDR_W-1:0] rd_base;
      logic [ADDR_W-1:0] wr_base;
   } cfg_t;

   state_t               state_q;
   cfg_t                 cfgTable_q [NUM_LAYER];
   cfg_t                 curCfg_q;
   logic [LIDX_W-1:0]    count_q;
   logic [LIDX_W-1:0]    lastLayer_q;
   logic [TIMEOUT_W-1:0] wd_q;
   logic                 error_q;
   logic [1:0]           errCode_q;
   logic                 done_q;
   logic                 rangeOk;

   assign rangeOk = (first_layer <= last_layer) && ({1'b0, last_layer} < LAYER_CNT);

   // The table is only writable between runs so a layer never sees its config change mid-flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_LAYER; i++) cfgTable_q[i] <= '0;
      end else if (cfg_we && (state_q == IDLE) && ({1'b0, cfg_waddr} < LAYER_CNT)) begin
         cfgTable_q[cfg_waddr] <= cfg_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         curCfg_q    <= '0;
         count_q     <= '0;
         lastLayer_q <= '0;
         wd_q        <= '0;
         error_q     <= 1'b0;
         errCode_q   <= 2'b00;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         // Abort outranks everything else in an active run.
         if ((state_q != IDLE) && abort) begin
            state_q   <= IDLE;
            error_q   <= 1'b1;
            errCode_q <= 2'b11;
            done_q    <= 1'b1;
         end else begin
            case (state_q)
               IDLE: begin
                  if (start_CNN) begin
                     if (rangeOk) begin
                        error_q     <= 1'b0;
                        errCode_q   <= 2'b00;
                        count_q     <= first_layer;
                        lastLayer_q <= last_layer;
                        state_q     <= LOAD;
                     end else begin
                        error_q   <= 1'b1;
                        errCode_q <= 2'b01;
                        done_q    <= 1'b1;
                     end
                  end
               end
               LOAD: begin
                  curCfg_q <= cfgTable_q[count_q];
                  state_q  <= START;
               end
               START: begin
                  wd_q    <= '0;
                  state_q <= WAIT;
               end
               WAIT: begin
                  if (eng.done_layer) begin
                     if (count_q == lastLayer_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                     end else begin
                        count_q <= count_q + LIDX_W'(1);
                        state_q <= LOAD;
                     end
                  end else if ((timeout_limit != '0) && (wd_q == timeout_limit)) begin
                     state_q   <= IDLE;
                     error_q   <= 1'b1;
                     errCode_q <= 2'b10;
                     done_q    <= 1'b1;
                  end else begin
                     wd_q <= wd_q + TIMEOUT_W'(1);
                  end
               end
               DONE: begin
                  state_q <= IDLE;
               end
               default: begin
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

   assign done_CNN    = done_q;
   assign busy        = (state_q != IDLE);
   assign error       = error_q;
   assign err_code    = errCode_q;
   assign count_layer = count_q;

   assign eng.start_layer      = (state_q == START);
   assign eng.ifm_size         = curCfg_q.ifm_size;
   assign eng.ifm_channel      = curCfg_q.ifm_channel;
   assign eng.kernel_size      = curCfg_q.kernel_size;
   assign eng.num_filter       = curCfg_q.num_filter;
   assign eng.maxpool_mode     = curCfg_q.maxpool_mode;
   assign eng.maxpool_stride   = curCfg_q.maxpool_stride;
   assign eng.upsample_mode    = curCfg_q.upsample_mode;
   assign eng.start_read_addr  = curCfg_q.rd_base;
   assign eng.start_write_addr = curCfg_q.wr_base;

endmodule
